io_bus_ctrl: RTL and testbench

Memory-mapped bus controller that sits directly downstream of the CPU core's byte memory port (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`) and produces the CPU's `io_buffer_full`. It decodes each byte access to either the 128 KB RAM or the I/O window (`mem_a[17:16]==2'b11`). It buffers UART transmit bytes in a FIFO, pops UART receive bytes, serves a coherent 32-bit cycle counter, and latches the program-stop event. Read data always returns exactly one cycle after the request, matching the CPU's memory contract.

---
 rtl/io_bus_ctrl_pkg.sv | 7 +
 rtl/io_bus_ctrl_if.sv | 10 +
 rtl/io_tx_fifo.sv | 37 +++
 rtl/io_bus_ctrl.sv | 89 ++++++++
 tb/tb_io_bus_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_ctrl_pkg.sv
// io_bus_ctrl_pkg: I/O window decode constants and return-path select encoding
package io_bus_ctrl_pkg;
  localparam logic [1:0] IO_BASE_HI = 2'b11;
  localparam logic [15:0] IO_UART = 16'h0000;
  localparam logic [15:0] IO_CLK = 16'h0004;
  typedef enum logic {SEL_RAM = 1'b0, SEL_IO = 1'b1} sel_t;
endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: CPU byte memory port with controller-side back-pressure
interface io_bus_ctrl_if;
  logic [31:0] mem_a;
  logic [7:0] mem_dout;
  logic mem_wr;
  logic [7:0] mem_din;
  logic io_buffer_full;
  modport master(output mem_a, mem_dout, mem_wr, input mem_din, io_buffer_full);
  modport slave(input mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);
endinterface

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: circular byte FIFO with extra-MSB pointers for full/empty detection
module io_tx_fifo #(
  parameter int DEPTH = 8
) (
  input logic clk_in,
  input logic rst_in,
  input logic push,
  input logic [7:0] push_data,
  input logic pop,
  output logic [7:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    count = wr_ptr - rd_ptr;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk_in)
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: decodes CPU byte accesses to RAM or the UART/clock I/O window
module io_bus_ctrl
  import io_bus_ctrl_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int FULL_MARGIN = 2,
  parameter int RAM_AW = 17
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  io_bus_ctrl_if.slave bus,
  output logic ram_en,
  output logic ram_wr,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0] ram_dout,
  input logic [7:0] ram_din,
  output logic [7:0] tx_data,
  output logic tx_valid,
  input logic tx_ready,
  input logic [7:0] rx_data,
  input logic rx_valid,
  output logic rx_pop,
  output logic program_stop,
  output logic tx_overflow
);
  localparam int CW = $clog2(TX_DEPTH);
  logic is_io, io_rd, io_wr, push, tx_pop, fifo_full, fifo_empty;
  logic [15:0] off;
  logic [7:0] push_data, io_rdata, io_byte_q;
  logic [31:0] cycle_cnt, snap;
  logic [CW:0] count, count_nxt;
  sel_t sel_q;
  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push(push),
    .push_data(push_data),
    .pop(tx_pop),
    .head(tx_data),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(count)
  );
  always_comb begin
    is_io = bus.mem_a[17:16] == IO_BASE_HI;
    off = bus.mem_a[15:0];
    io_rd = rdy_in && is_io && !bus.mem_wr;
    io_wr = rdy_in && is_io && bus.mem_wr;
    ram_en = rst_in && rdy_in && !is_io;
    ram_wr = bus.mem_wr;
    ram_a = bus.mem_a[RAM_AW-1:0];
    ram_dout = bus.mem_dout;
    rx_pop = rst_in && io_rd && off == IO_UART && rx_valid;
    push = io_wr && ((off == IO_UART && bus.mem_dout != 8'h00) || off == IO_CLK);
    push_data = off == IO_CLK ? 8'h00 : bus.mem_dout;
    tx_valid = !fifo_empty;
    tx_pop = tx_valid && tx_ready;
    count_nxt = count + (CW+1)'(push && (!fifo_full || tx_pop)) - (CW+1)'(tx_pop);
    io_rdata = !io_rd ? 8'h00 :
               off == IO_UART ? (rx_valid ? rx_data : 8'h00) :
               off == IO_CLK ? cycle_cnt[7:0] :
               off == IO_CLK + 16'd1 ? snap[15:8] :
               off == IO_CLK + 16'd2 ? snap[23:16] :
               off == IO_CLK + 16'd3 ? snap[31:24] : 8'h00;
    bus.mem_din = !rst_in ? 8'h00 : sel_q == SEL_RAM ? ram_din : io_byte_q;
  end
  // Back-pressure reflects occupancy after this edge; requests in flight ride on the margin.
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      cycle_cnt <= '0;
      snap <= '0;
      sel_q <= SEL_RAM;
      io_byte_q <= '0;
      bus.io_buffer_full <= 1'b0;
      program_stop <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      bus.io_buffer_full <= 32'(TX_DEPTH) - 32'(count_nxt) <= 32'(FULL_MARGIN);
      if (rdy_in) begin
        sel_q <= is_io ? SEL_IO : SEL_RAM;
        io_byte_q <= io_rdata;
        if (io_rd && off == IO_CLK) snap <= cycle_cnt;
        if (io_wr && off == IO_CLK) program_stop <= 1'b1;
        if (push && fifo_full && !tx_pop) tx_overflow <= 1'b1;
      end
    end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed stimulus checked against a queue-based behavioural model
module tb_io_bus_ctrl;
  localparam int DEPTH = 8;
  localparam int MARGIN = 2;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy = 1'b0;
  logic ram_en, ram_wr, tx_valid, rx_pop, program_stop, tx_overflow;
  logic [16:0] ram_a;
  logic [7:0] ram_dout, tx_data;
  logic [7:0] ram_din = 8'h00;
  logic tx_ready = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  bit run = 0;
  logic [7:0] q[$];
  logic [31:0] m_cnt = 0, m_snap = 0;
  logic [7:0] exp_din = 0;
  bit din_known = 0, m_stop = 0, m_ovf = 0, m_bfull = 0;
  io_bus_ctrl_if bus();
  io_bus_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy), .bus(bus),
    .ram_en(ram_en), .ram_wr(ram_wr), .ram_a(ram_a), .ram_dout(ram_dout), .ram_din(ram_din),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [7:0] ram_val(input logic [16:0] addr);
    return addr == 17'h10 ? 8'h5A : addr[7:0] ^ 8'hC3;
  endfunction
  always @(posedge clk_in) if (ram_en && !ram_wr) ram_din <= ram_val(ram_a);
  always @(posedge clk_in) if (rx_pop) pops <= pops + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_step(input logic [31:0] a, input logic [7:0] d, input logic wr, input logic r);
    bit io;
    int off;
    io = a[17:16] == 2'b11;
    off = int'(a[15:0]);
    if (q.size() > 0 && tx_ready) void'(q.pop_front());
    if (r) begin
      if (io && wr && ((off == 0 && d != 0) || off == 4)) begin
        if (off == 4) m_stop = 1;
        if (q.size() < DEPTH) q.push_back(off == 4 ? 8'h00 : d);
        else m_ovf = 1;
      end
      din_known = !wr;
      if (!wr) begin
        if (!io) exp_din = ram_val(a[16:0]);
        else if (off == 0) exp_din = rx_valid ? rx_data : 8'h00;
        else if (off == 4) begin
          exp_din = m_cnt[7:0];
          m_snap = m_cnt;
        end else if (off >= 5 && off <= 7) exp_din = m_snap[8*(off-4) +: 8];
        else exp_din = 8'h00;
      end
    end
    m_bfull = (DEPTH - q.size()) <= MARGIN;
    m_cnt++;
  endtask
  task automatic cyc(input logic [31:0] a, input logic [7:0] d, input logic wr, input logic r);
    bus.mem_a = a;
    bus.mem_dout = d;
    bus.mem_wr = wr;
    rdy = r;
    @(posedge clk_in);
    model_step(a, d, wr, r);
    #1;
  endtask
  task automatic idle();
    cyc(32'h10, 8'h00, 1'b0, 1'b1);
  endtask
  task automatic do_reset();
    run = 0;
    rst_in = 1'b0;
    bus.mem_a = 32'h10;
    bus.mem_dout = 8'h00;
    bus.mem_wr = 1'b0;
    rdy = 1'b1;
    #2;
    chk("rst_mem_din", bus.mem_din, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_buf_full", bus.io_buffer_full, 1'b0);
    chk("rst_stop", program_stop, 1'b0);
    chk("rst_ovf", tx_overflow, 1'b0);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_ram_en", ram_en, 1'b0);
    q.delete();
    m_cnt = 0;
    m_snap = 0;
    din_known = 0;
    m_stop = 0;
    m_ovf = 0;
    m_bfull = 0;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    run = 1;
  endtask
  always @(negedge clk_in) begin
    if (rst_in && run) begin
      logic io;
      logic [15:0] off;
      io = bus.mem_a[17:16] == 2'b11;
      off = bus.mem_a[15:0];
      chk("tx_valid", tx_valid, q.size() > 0);
      chk("tx_data", tx_data, q.size() > 0 ? q[0] : 8'h00);
      chk("buf_full", bus.io_buffer_full, m_bfull);
      chk("program_stop", program_stop, m_stop);
      chk("tx_overflow", tx_overflow, m_ovf);
      if (din_known) chk("mem_din", bus.mem_din, exp_din);
      chk("rx_pop", rx_pop, rdy && io && !bus.mem_wr && off == 16'h0 && rx_valid);
      chk("ram_en", ram_en, rdy && !io);
      if (rdy && !io) begin
        chk("ram_a", ram_a, bus.mem_a[16:0]);
        chk("ram_wr", ram_wr, bus.mem_wr);
        chk("ram_dout", ram_dout, bus.mem_dout);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    int p0;
    do_reset();
    // single push with UART ready, then a 0x00 write that must not push
    tx_ready = 1'b1;
    cyc(32'h30000, 8'h41, 1'b1, 1'b1);
    chk("push_valid", tx_valid, 1'b1);
    chk("push_data", tx_data, 8'h41);
    cyc(32'h30000, 8'h00, 1'b1, 1'b1);
    chk("zero_no_push", tx_valid, 1'b0);
    cyc(32'h20, 8'hAB, 1'b1, 1'b1);
    cyc(32'h30008, 8'h12, 1'b1, 1'b1);
    cyc(32'h30008, 8'h00, 1'b0, 1'b1);
    chk("other_io_rd", bus.mem_din, 8'h00);
    // fill with UART stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(32'h30000, 8'hA1 + 8'(i), 1'b1, 1'b1);
      if (i == 4) chk("bfull_after5", bus.io_buffer_full, 1'b0);
      if (i == 5) chk("bfull_after6", bus.io_buffer_full, 1'b1);
      if (i == 7) chk("ovf_after8", tx_overflow, 1'b0);
    end
    chk("ovf_after9", tx_overflow, 1'b1);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", tx_data, 8'hA1 + 8'(i));
      idle();
    end
    chk("drained", tx_valid, 1'b0);
    tx_ready = 1'b0;
    // coherent counter word read starting at cycle_cnt = 0xFF
    for (int i = 0; i < 400 && m_cnt != 32'hFF; i++) idle();
    chk("cnt_reach", m_cnt, 32'hFF);
    cyc(32'h30004, 8'h00, 1'b0, 1'b1);
    chk("clk_b0", bus.mem_din, 8'hFF);
    cyc(32'h30005, 8'h00, 1'b0, 1'b1);
    chk("clk_b1", bus.mem_din, 8'h00);
    cyc(32'h30006, 8'h00, 1'b0, 1'b1);
    chk("clk_b2", bus.mem_din, 8'h00);
    cyc(32'h30007, 8'h00, 1'b0, 1'b1);
    chk("clk_b3", bus.mem_din, 8'h00);
    // RAM read followed by UART receive read
    idle();
    chk("ram_rd", bus.mem_din, 8'h5A);
    rx_valid = 1'b1;
    rx_data = 8'h33;
    p0 = pops;
    cyc(32'h30000, 8'h00, 1'b0, 1'b1);
    chk("rx_rd", bus.mem_din, 8'h33);
    rx_valid = 1'b0;
    idle();
    chk("rx_pop_once", pops - p0, 1);
    // program stop then asynchronous reset mid-stream
    cyc(32'h30004, 8'h77, 1'b1, 1'b1);
    chk("stop_set", program_stop, 1'b1);
    chk("stop_push", tx_data, 8'h00);
    chk("stop_valid", tx_valid, 1'b1);
    do_reset();
    // rdy_in low gates all side effects
    idle();
    chk("pre_hold", bus.mem_din, 8'h5A);
    rx_valid = 1'b1;
    rx_data = 8'h99;
    p0 = pops;
    cyc(32'h30000, 8'h55, 1'b1, 1'b0);
    cyc(32'h30000, 8'h00, 1'b0, 1'b0);
    chk("hold_no_push", tx_valid, 1'b0);
    chk("hold_din", bus.mem_din, 8'h5A);
    chk("hold_no_pop", pops - p0, 0);
    rx_valid = 1'b0;
    // push and pop together while full: push must succeed without overflow
    for (int i = 0; i < 8; i++) cyc(32'h30000, 8'hB0 + 8'(i), 1'b1, 1'b1);
    tx_ready = 1'b1;
    cyc(32'h30000, 8'hC0, 1'b1, 1'b1);
    chk("full_pushpop_ovf", tx_overflow, 1'b0);
    chk("full_pushpop_head", tx_data, 8'hB1);
    for (int i = 0; i < 8; i++) idle();
    chk("last_out", tx_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
